// File: rtl/pe_multilane_mac.sv
// pe_multilane_mac: LANES-wide signed MAC processing element.
// Each lane accumulates a window of K ifmap*fltr products and adds an upstream
// psum (or zero when bypassed). The lanes emit their psums together over a
// valid/ready handshake. Accepted ifmap beats are forwarded to the
// neighbouring PE K beats later.
// Optional macro PE_SAT_EN: accumulator adds saturate instead of wrapping.
// Ports:
//   clk, rstn                        clock, synchronous active-low reset
//   cfg_kernel_size, cfg_psum_bypass window config, latched on the first beat
//   in_valid/in_ready, ifmap_in, fltr_in             ifmap/filter beat input
//   psum_in_valid/psum_in_ready, psum_in             upstream partial sums
//   psum_out_valid/psum_out_ready, psum_out          output partial sums
//   ifmap_fwd_valid, ifmap_fwd                       forwarded ifmap beat
//   busy                                             FSM not idle
module pe_multilane_mac #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LANES      = 4,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter int unsigned MAX_KERNEL = 8,
  parameter int unsigned KW         = $clog2(MAX_KERNEL + 1)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [KW-1:0]                 cfg_kernel_size,
  input  logic                          cfg_psum_bypass,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]   ifmap_in,
  input  logic [LANES*DATA_WIDTH-1:0]   fltr_in,
  input  logic                          psum_in_valid,
  output logic                          psum_in_ready,
  input  logic [LANES*ACC_WIDTH-1:0]    psum_in,
  output logic                          psum_out_valid,
  input  logic                          psum_out_ready,
  output logic [LANES*ACC_WIDTH-1:0]    psum_out,
  output logic                          ifmap_fwd_valid,
  output logic [LANES*DATA_WIDTH-1:0]   ifmap_fwd,
  output logic                          busy
);

  localparam int unsigned PW  = 2 * DATA_WIDTH;
  localparam int unsigned DLW = (MAX_KERNEL > 1) ? $clog2(MAX_KERNEL) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ACC, S_DRAIN, S_PSUM, S_OUT} state_e;

  state_e                        state_q, state_d;
  logic [KW-1:0]                 k_q, k_d, cnt_q, cnt_d, k_new, k_use;
  logic                          byp_q, byp_d;
  logic signed [PW-1:0]          prod_q [LANES];
  logic signed [PW-1:0]          prod_d [LANES];
  logic                          prod_vld_q, prod_vld_d;
  logic signed [ACC_WIDTH-1:0]   acc_q [LANES];
  logic signed [ACC_WIDTH-1:0]   acc_d [LANES];
  logic                          in_ready_q, in_ready_d;
  logic                          psum_in_ready_q, psum_in_ready_d;
  logic                          psum_out_valid_q, psum_out_valid_d;
  logic                          busy_q, busy_d;
  logic [LANES*ACC_WIDTH-1:0]    psum_out_q, psum_out_d;
  logic                          fwd_valid_q, fwd_valid_d;
  logic [LANES*DATA_WIDTH-1:0]   fwd_q, fwd_d;
  logic [LANES*DATA_WIDTH-1:0]   dl_data_q [MAX_KERNEL];
  logic [LANES*DATA_WIDTH-1:0]   dl_data_d [MAX_KERNEL];
  logic [MAX_KERNEL-1:0]         dl_vld_q, dl_vld_d;
  logic [DLW-1:0]                tap;
  logic                          beat_acc, psum_hs, out_hs;

  // Accumulator add: wraps by default, saturates under PE_SAT_EN.
  function automatic logic signed [ACC_WIDTH-1:0] acc_add(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [ACC_WIDTH-1:0] b
  );
`ifdef PE_SAT_EN
    logic signed [ACC_WIDTH:0] s;
    s = (ACC_WIDTH+1)'(a) + (ACC_WIDTH+1)'(b);
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
      return s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    return s[ACC_WIDTH-1:0];
`else
    return a + b;
`endif
  endfunction

  assign beat_acc = in_valid & in_ready_q;
  assign psum_hs  = psum_in_valid & psum_in_ready_q;
  assign out_hs   = psum_out_valid_q & psum_out_ready;

  // Kernel size sanitising: 0 -> 1, oversize -> MAX_KERNEL.
  always_comb begin
    k_new = cfg_kernel_size;
    if (cfg_kernel_size == '0)                   k_new = KW'(1);
    else if (cfg_kernel_size > KW'(MAX_KERNEL))  k_new = KW'(MAX_KERNEL);
  end

  // The first beat of a window taps the delay line with the K it is latching.
  assign k_use = (state_q == S_IDLE) ? k_new : k_q;
  assign tap   = DLW'(k_use - KW'(1));

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    byp_d       = byp_q;
    cnt_d       = cnt_q;
    prod_vld_d  = beat_acc;
    psum_out_d  = psum_out_q;
    fwd_valid_d = 1'b0;
    fwd_d       = fwd_q;
    dl_data_d   = dl_data_q;
    dl_vld_d    = dl_vld_q;

    for (int unsigned l = 0; l < LANES; l++) begin
      prod_d[l] = beat_acc
        ? PW'($signed(ifmap_in[l*DATA_WIDTH +: DATA_WIDTH])) *
          PW'($signed(fltr_in[l*DATA_WIDTH +: DATA_WIDTH]))
        : prod_q[l];
      acc_d[l]  = prod_vld_q ? acc_add(acc_q[l], ACC_WIDTH'(prod_q[l])) : acc_q[l];
    end

    case (state_q)
      S_IDLE: if (beat_acc) begin
        k_d   = k_new;
        byp_d = cfg_psum_bypass;
        cnt_d = KW'(1);
        for (int unsigned l = 0; l < LANES; l++) acc_d[l] = '0;
        state_d = (k_new == KW'(1)) ? S_DRAIN : S_ACC;
      end
      S_ACC: if (beat_acc) begin
        cnt_d = cnt_q + KW'(1);
        if ((cnt_q + KW'(1)) == k_q) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = byp_q ? S_OUT : S_PSUM;
      S_PSUM: if (psum_hs) begin
        for (int unsigned l = 0; l < LANES; l++)
          acc_d[l] = acc_add(acc_q[l], $signed(psum_in[l*ACC_WIDTH +: ACC_WIDTH]));
        state_d = S_OUT;
      end
      S_OUT: if (out_hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Capture the final window sum as the FSM enters OUT.
    if ((state_q == S_DRAIN && byp_q) || (state_q == S_PSUM && psum_hs)) begin
      for (int unsigned l = 0; l < LANES; l++)
        psum_out_d[l*ACC_WIDTH +: ACC_WIDTH] = acc_d[l];
    end

    // Delay line advances only on accepted beats; entry K-1 is beat n-K.
    if (beat_acc) begin
      fwd_valid_d = dl_vld_q[tap];
      if (dl_vld_q[tap]) fwd_d = dl_data_q[tap];
      dl_data_d[0] = ifmap_in;
      dl_vld_d[0]  = 1'b1;
      for (int unsigned i = 1; i < MAX_KERNEL; i++) begin
        dl_data_d[i] = dl_data_q[i-1];
        dl_vld_d[i]  = dl_vld_q[i-1];
      end
    end

    in_ready_d       = (state_d == S_IDLE) || (state_d == S_ACC);
    psum_in_ready_d  = (state_d == S_PSUM);
    psum_out_valid_d = (state_d == S_OUT);
    busy_d           = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q          <= S_IDLE;
      k_q              <= KW'(1);
      byp_q            <= 1'b0;
      cnt_q            <= '0;
      prod_vld_q       <= 1'b0;
      in_ready_q       <= 1'b0;
      psum_in_ready_q  <= 1'b0;
      psum_out_valid_q <= 1'b0;
      busy_q           <= 1'b0;
      psum_out_q       <= '0;
      fwd_valid_q      <= 1'b0;
      fwd_q            <= '0;
      dl_vld_q         <= '0;
      for (int unsigned l = 0; l < LANES; l++) begin
        prod_q[l] <= '0;
        acc_q[l]  <= '0;
      end
      for (int unsigned i = 0; i < MAX_KERNEL; i++) dl_data_q[i] <= '0;
    end else begin
      state_q          <= state_d;
      k_q              <= k_d;
      byp_q            <= byp_d;
      cnt_q            <= cnt_d;
      prod_vld_q       <= prod_vld_d;
      in_ready_q       <= in_ready_d;
      psum_in_ready_q  <= psum_in_ready_d;
      psum_out_valid_q <= psum_out_valid_d;
      busy_q           <= busy_d;
      psum_out_q       <= psum_out_d;
      fwd_valid_q      <= fwd_valid_d;
      fwd_q            <= fwd_d;
      dl_vld_q         <= dl_vld_d;
      prod_q           <= prod_d;
      acc_q            <= acc_d;
      dl_data_q        <= dl_data_d;
    end
  end

  assign in_ready        = in_ready_q;
  assign psum_in_ready   = psum_in_ready_q;
  assign psum_out_valid  = psum_out_valid_q;
  assign psum_out        = psum_out_q;
  assign ifmap_fwd_valid = fwd_valid_q;
  assign ifmap_fwd       = fwd_q;
  assign busy            = busy_q;

endmodule
